pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, segmented-carry pipelined adder/subtractor. It is the next generation of the team's single-register adder.
- Splits the carry chain into SEG_WIDTH-bit stages so wide operands close timing.
- Adds a subtract mode, carry-in, a signed-overflow flag, a sideband tag, and a valid/ready handshake with bubble-collapsing backpressure.
- Sits between operand-producing logic and any consumer that may stall.

Parameters:
- DATA_WIDTH, 32, operand width in bits (>=1).
- SEG_WIDTH, 8, carry-segment width per pipeline stage (1..DATA_WIDTH).
- TAG_WIDTH, 4, sideband tag width carried alongside each operation (>=1).
- Derived constant: STAGES = ceil(DATA_WIDTH/SEG_WIDTH). The last segment may be narrower.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  DATA_WIDTH  operand A
- b  input  DATA_WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- in_tag  input  TAG_WIDTH  sideband tag
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  DATA_WIDTH+1  result; MSB = carry-out (add) / not-borrow (sub)
- ovf  output  1  two's-complement signed overflow of the DATA_WIDTH-bit result
- out_tag  output  TAG_WIDTH  tag of the result beat

Behaviour:
- Reset (async, rst=1): all stage valid bits 0; out_valid=0; sum=0; ovf=0; out_tag=0; in_ready=1 once rst deasserts. In-flight beats are discarded and never emitted.
- Transfer occurs on the rising clk edge when valid && ready, on both the input and the output side.
- Arithmetic, where N = DATA_WIDTH:
  - Add: sum = a + b + cin, zero-extended to N+1 bits.
  - Sub: sum = a + ~b + ~cin, computed N+1 bits wide. Value = a - b - cin mod 2^N; sum[N] = 1 when no borrow.
  - ovf = (A[N-1] == B'[N-1]) && (sum[N-1] != A[N-1]), where B' is b for add and ~b for sub.
- Pipeline:
  - Stage k (0..STAGES-1) computes sum bits [k*SEG_WIDTH +: SEG_WIDTH] from the registered carry of stage k-1. Stage 0 uses cin (add) or ~cin (sub).
  - Operand segments not yet consumed, plus sub and tag, are delayed alongside.
  - The final stage registers sum, ovf and out_tag.
- Latency: exactly STAGES cycles from input transfer to out_valid when unstalled. Throughput is 1 beat per cycle.
- Backpressure and bubble collapse:
  - A stage loads when it is empty or its contents advance this cycle.
  - in_ready = stage-0 empty || stage 0 advancing. It is combinational from out_ready only through the stage chain.
  - Up to STAGES beats are held when out_ready=0.
- While out_valid=1 and out_ready=0, sum/ovf/out_tag remain stable.
- Beats are never reordered, dropped or duplicated.
- Simultaneous input and output transfer with the pipeline full: both occur and occupancy is unchanged.
- STAGES=1 degenerates to a single registered adder plus a skid-free handshake.
- Widths wrap modulo 2^(N+1); no saturation.

Test Plan:
- Add, DATA_WIDTH=8, SEG_WIDTH=3 (STAGES=3): a=0xFF, b=0x01, cin=0, tag=5 -> 3 cycles later sum=0x100, ovf=0, out_tag=5.
- Signed overflow add: a=0x7F, b=0x01, cin=0 -> sum=0x080, ovf=1. Same with cin=1, a=0x7F, b=0x00 -> sum=0x080, ovf=1.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 -> sum=0x0FE (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x17F, ovf=1.
- Backpressure: hold out_ready=0 and stream tags 1..5 back-to-back -> in_ready drops after 3 accepted. Raise out_ready -> results emitted in order 1..5, each beat stable while stalled, no gaps when out_ready stays 1.
- Bubbles: insert in_valid gaps with random out_ready (seeded, 1000 beats) -> scoreboard matches the reference arithmetic and tag order, zero loss or duplication.
- Reset mid-operation: 2 beats in flight, pulse rst for a partial cycle -> out_valid=0 and sum=0 immediately. Neither beat is emitted afterwards, and the next accepted beat appears after exactly STAGES cycles.

Source files
------------

// File: rtl/pipelined_adder.sv
// Segmented-carry pipelined adder/subtractor with valid/ready handshake.
// The carry chain is cut into SEG_WIDTH-bit slices with one register stage per slice.
// Each stage holds the sum bits already resolved, its carry-out, and the operand bits
// that later stages still need. The tag travels with the beat.
// Every stage can accept a new beat in the same cycle its current beat moves on, so
// bubbles collapse and a stalled consumer leaves up to STAGES beats buffered.
module pipelined_adder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEG_WIDTH  = 8,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  input  logic                  sub,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   sum,
  output logic                  ovf,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int unsigned Stages = (DATA_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int unsigned Last   = Stages - 1;

  for (genvar k = 0; k < Stages; k++) begin : g_stage
    // Bit range of the sum resolved by this stage; the top slice may be narrower.
    localparam int unsigned Lo = k * SEG_WIDTH;
    localparam int unsigned Hi = (Lo + SEG_WIDTH > DATA_WIDTH) ? DATA_WIDTH : Lo + SEG_WIDTH;
    localparam int unsigned W  = Hi - Lo;

    // Beat arriving from upstream (primary inputs for stage 0).
    logic                  src_valid;
    logic                  src_carry;
    logic [DATA_WIDTH-1:Lo] src_a;
    logic [DATA_WIDTH-1:Lo] src_bx;  // b, already inverted for subtract
    logic [TAG_WIDTH-1:0]  src_tag;

    logic [W:0]            seg_res;
    logic [Hi-1:0]         sum_d;
    logic                  next_ready;
    logic                  ready;

    logic                  valid_q;
    logic                  carry_q;
    logic [Hi-1:0]         sum_q;
    logic [TAG_WIDTH-1:0]  tag_q;

    if (k == 0) begin : g_src
      // Subtract is a + ~b + ~cin: invert b and the incoming borrow once, up front.
      assign src_valid = in_valid;
      assign src_a     = a;
      assign src_bx    = b ^ {DATA_WIDTH{sub}};
      assign src_carry = cin ^ sub;
      assign src_tag   = in_tag;
      assign sum_d     = seg_res[W-1:0];
    end else begin : g_src
      assign src_valid = g_stage[k-1].valid_q;
      assign src_a     = g_stage[k-1].g_ops.a_q;
      assign src_bx    = g_stage[k-1].g_ops.bx_q;
      assign src_carry = g_stage[k-1].carry_q;
      assign src_tag   = g_stage[k-1].tag_q;
      assign sum_d     = {seg_res[W-1:0], g_stage[k-1].sum_q};
    end

    // One slice of the carry chain, fed by the registered carry of the previous slice.
    assign seg_res = {1'b0, src_a[Hi-1:Lo]} + {1'b0, src_bx[Hi-1:Lo]} + {{W{1'b0}}, src_carry};

    if (k == Last) begin : g_next
      assign next_ready = out_ready;
    end else begin : g_next
      assign next_ready = g_stage[k+1].ready;
    end

    // Load when empty or when the current beat moves on this cycle.
    assign ready = !valid_q || next_ready;

    // Stage register; payload only captured for real beats so a stalled or idle
    // stage keeps its contents steady.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
        tag_q   <= '0;
      end else if (ready) begin
        valid_q <= src_valid;
        if (src_valid) begin
          carry_q <= seg_res[W];
          sum_q   <= sum_d;
          tag_q   <= src_tag;
        end
      end
    end

    if (k < Last) begin : g_ops
      // Operand bits not yet consumed by the carry chain.
      logic [DATA_WIDTH-1:Hi] a_q;
      logic [DATA_WIDTH-1:Hi] bx_q;

      // Delay the remaining operand slices alongside the beat.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (ready && src_valid) begin
          a_q  <= src_a[DATA_WIDTH-1:Hi];
          bx_q <= src_bx[DATA_WIDTH-1:Hi];
        end
      end
    end else begin : g_tail
      logic ovf_d;
      logic ovf_q;

      // Signed overflow: operands agree in sign but the result does not.
      assign ovf_d = (src_a[DATA_WIDTH-1] == src_bx[DATA_WIDTH-1]) &&
                     (seg_res[W-1] != src_a[DATA_WIDTH-1]);

      // Overflow flag registered with the final sum slice.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (ready && src_valid) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].ready;
  assign out_valid = g_stage[Last].valid_q;
  assign sum       = {g_stage[Last].carry_q, g_stage[Last].sum_q};
  assign ovf       = g_stage[Last].g_tail.ovf_q;
  assign out_tag   = g_stage[Last].tag_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and seeded-stream bench for pipelined_adder at 8-bit data, 3-bit segments.
module tb_pipelined_adder;

  localparam int unsigned DW     = 8;
  localparam int unsigned SW     = 3;
  localparam int unsigned TW     = 4;
  localparam int          Stages = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
  logic          sub;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   sum;
  logic          ovf;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(
    .DATA_WIDTH(DW),
    .SEG_WIDTH (SW),
    .TAG_WIDTH (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .ovf      (ovf),
    .out_tag  (out_tag)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [3:0] tag;
    logic [8:0] exp_sum;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference from integer arithmetic: {ovf, sum[8:0]}.
  function automatic logic [9:0] ref_calc(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic rcin, input logic rsub);
    int ua, ub, sa, sb, u, s;
    logic [8:0] r;
    logic       o;
    ua = int'(ra);
    ub = int'(rb);
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (!rsub) begin
      u = ua + ub + int'(rcin);
      r = u[8:0];
      s = sa + sb + int'(rcin);
    end else begin
      u = ua - ub - int'(rcin);
      r = {(u >= 0), u[7:0]};
      s = sa - sb - int'(rcin);
    end
    o = (s > 127) || (s < -128);
    return {o, r};
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    sub      = 1'b0;
    in_tag   = '0;
  endtask

  // Single beat into an empty pipe with out_ready=1; checks latency and result.
  task automatic run_one(input string name, input logic [7:0] va, input logic [7:0] vb,
                         input logic vcin, input logic vsub, input logic [3:0] vtag,
                         input logic [8:0] esum, input logic eovf);
    int cyc;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vcin;
    sub      = vsub;
    in_tag   = vtag;
    #1;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    idle_inputs();
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(Stages));
    check({name, " sum"}, 32'(sum), 32'(esum));
    check({name, " ovf"}, 32'(ovf), 32'(eovf));
    check({name, " tag"}, 32'(out_tag), 32'(vtag));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0]  rng;
    logic [13:0]  exp_q[$];
    logic [13:0]  got;
    logic [13:0]  held;
    logic [9:0]   r;
    logic         prev_stall;
    logic         have_held;
    logic         fire;
    int           n_acc, n_out, first_out, last_out, sent, recv, cyc, seen;

    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 4'd5,  9'h100, 1'b0};
    vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 4'd1,  9'h080, 1'b1};
    vecs[2]  = '{8'h7F, 8'h00, 1'b1, 1'b0, 4'd2,  9'h080, 1'b1};
    vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 4'd3,  9'h0FE, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 4'd4,  9'h17F, 1'b1};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 4'd6,  9'h1FF, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 1'b1, 4'd7,  9'h0FF, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 4'd8,  9'h100, 1'b0};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 4'd9,  9'h100, 1'b1};
    vecs[9]  = '{8'h5A, 8'hA5, 1'b1, 1'b0, 4'd10, 9'h100, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 4'd11, 9'h080, 1'b1};
    vecs[11] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 4'd12, 9'h04B, 1'b0};

    // Reset state
    rst       = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    tick();

    // Directed vectors
    foreach (vecs[i]) begin
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
              vecs[i].tag, vecs[i].exp_sum, vecs[i].exp_ovf);
    end

    // Backpressure: consumer stalled, beats 1..5 offered back to back
    out_ready = 1'b0;
    n_acc     = 0;
    have_held = 1'b0;
    held      = '0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        if (!have_held) begin
          held      = {out_tag, ovf, sum};
          have_held = 1'b1;
        end else begin
          check("stall stable", 32'({out_tag, ovf, sum}), 32'(held));
        end
      end
      in_valid = 1'b1;
      in_tag   = 4'(n_acc + 1);
      a        = 8'((n_acc + 1) * 17);
      b        = 8'((n_acc + 1) * 3 + 1);
      #1;
      fire = in_ready;
      tick();
      if (fire) n_acc++;
    end
    check("bp accepted", 32'(n_acc), 32'd3);
    check("bp in_ready low", 32'(in_ready), 32'd0);
    r = ref_calc(8'd17, 8'd4, 1'b0, 1'b0);
    check("bp head", 32'({out_valid, out_tag, ovf, sum}), 32'({1'b1, 4'd1, r}));

    out_ready = 1'b1;
    n_out     = 0;
    first_out = -1;
    last_out  = -1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        r = ref_calc(8'((n_out + 1) * 17), 8'((n_out + 1) * 3 + 1), 1'b0, 1'b0);
        check("bp order", 32'({out_tag, ovf, sum}), 32'({4'(n_out + 1), r}));
        if (first_out < 0) first_out = c;
        last_out = c;
        n_out++;
      end
      if (n_acc < 5) begin
        in_valid = 1'b1;
        in_tag   = 4'(n_acc + 1);
        a        = 8'((n_acc + 1) * 17);
        b        = 8'((n_acc + 1) * 3 + 1);
      end else begin
        idle_inputs();
      end
      #1;
      fire = in_valid && in_ready;
      tick();
      if (fire) n_acc++;
    end
    check("bp drained", 32'(n_out), 32'd5);
    check("bp no gaps", 32'(last_out - first_out + 1), 32'd5);

    // Seeded stream with bubbles and random backpressure
    rng        = 32'h1234_5678;
    sent       = 0;
    recv       = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    held       = '0;
    while (recv < 1000 && cyc < 20000) begin
      if (prev_stall) begin
        check("rand stall stable", 32'({out_valid, out_tag, ovf, sum}), 32'({1'b1, held}));
      end
      rng = rng ^ (rng << 13);
      rng = rng ^ (rng >> 17);
      rng = rng ^ (rng << 5);
      out_ready = (rng[1:0] != 2'b00);
      if (sent < 1000 && rng[4:2] > 3'd2) begin
        in_valid = 1'b1;
        a        = rng[15:8];
        b        = rng[23:16];
        cin      = rng[24];
        sub      = rng[25];
        in_tag   = 4'(sent);
      end else begin
        idle_inputs();
      end
      #1;
      if (in_valid && in_ready) begin
        r = ref_calc(a, b, cin, sub);
        exp_q.push_back({in_tag, r});
        sent++;
      end
      if (out_valid && out_ready) begin
        got = {out_tag, ovf, sum};
        if (exp_q.size() == 0) begin
          check("rand unexpected beat", 32'(got), 32'h3FFFF);
        end else begin
          check("rand beat", 32'(got), 32'(exp_q.pop_front()));
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_tag, ovf, sum};
      tick();
      cyc++;
    end
    idle_inputs();
    out_ready = 1'b1;
    check("rand received", 32'(recv), 32'd1000);
    check("rand leftover", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    tick();
    tick();

    // Reset with two beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a        = 8'h21 + 8'(i);
      b        = 8'h42;
      in_tag   = 4'(13 + i);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset sum", 32'(sum), 32'd0);
    check("midreset ovf_tag", 32'({ovf, out_tag}), 32'd0);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("postreset in_ready", 32'(in_ready), 32'd1);
    tick();
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("flushed beats", 32'(seen), 32'd0);
    run_one("after reset", 8'hC3, 8'h3D, 1'b1, 1'b1, 4'd14, 9'h185, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
